imem_sequencer: RTL and testbench

IMEM_SEQUENCER -- requirements
Module: imem_sequencer

---
 rtl/isa_pkg.sv | 34 +++
 rtl/imem_sequencer.sv | 142 ++++++++++++++
 tb/tb_imem_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA types for the instruction-memory sequencer and the control unit.
//   pc_reg_t       : program counter / instruction memory address
//   instruction_t  : one instruction word
//   seq_state_t    : sequencer FSM states
//   get_opcode()   : extracts the opcode field from an instruction
package isa_pkg;

  localparam int unsigned PROGRAM_COUNTER_LENGTH = 4;
  localparam int unsigned INSTRUCTION_LENGTH     = 16;
  localparam int unsigned OPCODE_LENGTH          = 4;
  localparam int unsigned OPERAND_LENGTH         = INSTRUCTION_LENGTH - OPCODE_LENGTH;

  typedef logic [PROGRAM_COUNTER_LENGTH-1:0] pc_reg_t;
  typedef logic [INSTRUCTION_LENGTH-1:0]     instruction_t;
  typedef logic [OPCODE_LENGTH-1:0]          opcode_t;

  localparam opcode_t      OPC_NOP   = 4'h0;
  localparam opcode_t      OPC_HALT  = 4'hF;
  localparam instruction_t NOP_INSTR = {OPC_NOP, OPERAND_LENGTH'(0)};
  localparam pc_reg_t      PC_MAX    = '1;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD   = 3'd1,
    SEQ_BOOT   = 3'd2,
    SEQ_RUN    = 3'd3,
    SEQ_HALTED = 3'd4
  } seq_state_t;

  function automatic opcode_t get_opcode(input instruction_t instr);
    return instr[INSTRUCTION_LENGTH-1 -: OPCODE_LENGTH];
  endfunction

endpackage

// File: rtl/imem_sequencer.sv
// imem_sequencer: loads a program from a host stream into a single-port
// instruction memory, boots the control unit from address 0, runs it until
// a HALT opcode is fetched, and then waits for a reload.
//
// Optional feature: define PERF_COUNTER_EN to build the RUN-cycle counter;
// otherwise cycle_count is tied to 0.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   host_*        : valid/ready load stream (data, last-word flag)
//   start         : begin load-and-run (accepted in IDLE and HALTED only)
//   busy, halted  : status
//   core_rst      : synchronous reset to the control unit (low only in RUN)
//   core_next_pc  : control unit's next program counter
//   fetch_instr   : instruction presented to the control unit (NOP unless RUN)
//   imem_*        : instruction memory port, one-cycle read latency
//   cycle_count   : RUN-cycle count
module imem_sequencer
  import isa_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         host_valid,
  output logic         host_ready,
  input  instruction_t host_data,
  input  logic         host_last,
  input  logic         start,
  output logic         busy,
  output logic         halted,
  output logic         core_rst,
  input  pc_reg_t      core_next_pc,
  output instruction_t fetch_instr,
  output pc_reg_t      imem_addr,
  output logic         imem_we,
  output instruction_t imem_wdata,
  input  instruction_t imem_rdata,
  output logic [31:0]  cycle_count
);

  seq_state_t r_state;
  seq_state_t w_next_state;
  pc_reg_t    r_load_addr;
  logic       w_accept;
  logic       w_load_done;
  logic       w_start_load;

  // Host words are only consumed in LOAD; a load ends on host_last or on the top address.
  assign w_accept     = (r_state == SEQ_LOAD) && host_valid;
  assign w_load_done  = w_accept && (host_last || (r_load_addr == PC_MAX));
  assign w_start_load = ((r_state == SEQ_IDLE) || (r_state == SEQ_HALTED)) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SEQ_IDLE:   if (start) w_next_state = SEQ_LOAD;
      SEQ_LOAD:   if (w_load_done) w_next_state = SEQ_BOOT;
      SEQ_BOOT:   w_next_state = SEQ_RUN;
      // imem_rdata is exactly what fetch_instr shows in RUN
      SEQ_RUN:    if (get_opcode(imem_rdata) == OPC_HALT) w_next_state = SEQ_HALTED;
      SEQ_HALTED: if (start) w_next_state = SEQ_LOAD;
      default:    w_next_state = SEQ_IDLE;
    endcase
  end

  // Load address: cleared when a load begins, saturates at the top address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_addr <= '0;
    end else if (w_start_load) begin
      r_load_addr <= '0;
    end else if (w_accept && (r_load_addr != PC_MAX)) begin
      r_load_addr <= pc_reg_t'(r_load_addr + 1'b1);
    end
  end

  // Output decode: one memory user per state
  always_comb begin
    host_ready  = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    core_rst    = 1'b1;
    fetch_instr = NOP_INSTR;
    imem_addr   = '0;
    imem_we     = 1'b0;
    imem_wdata  = NOP_INSTR;
    case (r_state)
      SEQ_IDLE: begin
        busy = 1'b0;
      end
      SEQ_LOAD: begin
        host_ready = 1'b1;
        imem_addr  = r_load_addr;
        imem_we    = host_valid;
        imem_wdata = host_data;
      end
      SEQ_BOOT: begin
        imem_addr = '0;
      end
      SEQ_RUN: begin
        core_rst    = 1'b0;
        imem_addr   = core_next_pc;
        fetch_instr = imem_rdata;
      end
      SEQ_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

`ifdef PERF_COUNTER_EN
  logic [31:0] r_cycle_count;

  // RUN-cycle counter: cleared on entry to BOOT, saturating, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
    end else if (w_load_done) begin
      r_cycle_count <= '0;
    end else if ((r_state == SEQ_RUN) && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_imem_sequencer.sv
// tb_imem_sequencer: directed bench for imem_sequencer with a behavioural
// single-port memory (one-cycle read) and a minimal program-counter model.
module tb_imem_sequencer;
  import isa_pkg::*;

`ifdef PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         host_valid;
  logic         host_ready;
  instruction_t host_data;
  logic         host_last;
  logic         start;
  logic         busy;
  logic         halted;
  logic         core_rst;
  pc_reg_t      core_next_pc;
  instruction_t fetch_instr;
  pc_reg_t      imem_addr;
  logic         imem_we;
  instruction_t imem_wdata;
  instruction_t imem_rdata;
  logic [31:0]  cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  instruction_t mem [0:(1<<PROGRAM_COUNTER_LENGTH)-1];
  pc_reg_t      wr_addr_q [$];
  instruction_t wr_data_q [$];
  pc_reg_t      r_pc;

  imem_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_data    (host_data),
    .host_last    (host_last),
    .start        (start),
    .busy         (busy),
    .halted       (halted),
    .core_rst     (core_rst),
    .core_next_pc (core_next_pc),
    .fetch_instr  (fetch_instr),
    .imem_addr    (imem_addr),
    .imem_we      (imem_we),
    .imem_wdata   (imem_wdata),
    .imem_rdata   (imem_rdata),
    .cycle_count  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a write log
  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    imem_rdata <= mem[imem_addr];
  end

  // Control unit stand-in: sequential PC held at 0 while in reset
  always @(posedge clk) begin
    if (core_rst) r_pc <= '0;
    else          r_pc <= core_next_pc;
  end
  assign core_next_pc = pc_reg_t'(r_pc + 1'b1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  instruction_t prog [4];

  initial begin
    rst_n      = 1'b0;
    host_valid = 1'b0;
    host_data  = '0;
    host_last  = 1'b0;
    start      = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    prog[0] = 16'h1001;
    prog[1] = 16'h2002;
    prog[2] = 16'hF000;
    prog[3] = 16'h3003;

    // Reset state
    step();
    step();
    check("rst_busy",        32'(busy), 32'd0);
    check("rst_host_ready",  32'(host_ready), 32'd0);
    check("rst_halted",      32'(halted), 32'd0);
    check("rst_core_rst",    32'(core_rst), 32'd1);
    check("rst_imem_we",     32'(imem_we), 32'd0);
    check("rst_imem_addr",   32'(imem_addr), 32'd0);
    check("rst_cycle_count", cycle_count, 32'd0);
    check("rst_fetch_nop",   32'(fetch_instr), 32'(NOP_INSTR));
    rst_n = 1'b1;
    step();

    // start together with host_valid in IDLE: transition only, no write
    start = 1'b1; host_valid = 1'b1; host_data = 16'hDEAD;
    #1;
    check("idle_start_no_we", 32'(imem_we), 32'd0);
    check("idle_no_ready",    32'(host_ready), 32'd0);
    step();
    start = 1'b0;

    // W0, gap, W1: two writes, address advances by 2
    host_data = prog[0];
    #1;
    check("load_ready", 32'(host_ready), 32'd1);
    check("load_busy",  32'(busy), 32'd1);
    check("load_addr0", 32'(imem_addr), 32'd0);
    step();
    host_valid = 1'b0;
    #1;
    check("load_gap_no_we", 32'(imem_we), 32'd0);
    step();
    host_valid = 1'b1; host_data = prog[1];
    step();
    host_valid = 1'b0;
    #1;
    check("toggle_addr", 32'(imem_addr), 32'd2);
    check("toggle_writes", 32'(wr_addr_q.size()), 32'd2);
    host_valid = 1'b1; host_data = prog[2];
    step();
    host_data = prog[3]; host_last = 1'b1;
    step();
    host_valid = 1'b0; host_last = 1'b0;
    #1;
    // BOOT
    check("boot_addr",     32'(imem_addr), 32'd0);
    check("boot_we",       32'(imem_we), 32'd0);
    check("boot_core_rst", 32'(core_rst), 32'd1);
    check("boot_fetch",    32'(fetch_instr), 32'(NOP_INSTR));
    check("boot_ready",    32'(host_ready), 32'd0);
    check("load4_writes",  32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check($sformatf("load4_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
      check($sformatf("load4_data%0d", i), 32'(wr_data_q[i]), 32'(prog[i]));
    end
    step();
    // RUN
    check("run_core_rst", 32'(core_rst), 32'd0);
    check("run_fetch0",   32'(fetch_instr), 32'(prog[0]));
    check("run_halted0",  32'(halted), 32'd0);
    step();
    check("run_fetch1", 32'(fetch_instr), 32'(prog[1]));
    step();
    check("run_fetch2", 32'(fetch_instr), 32'(prog[2]));
    step();
    // HALTED
    check("halt_halted",   32'(halted), 32'd1);
    check("halt_core_rst", 32'(core_rst), 32'd1);
    check("halt_busy",     32'(busy), 32'd1);
    check("halt_fetch",    32'(fetch_instr), 32'(NOP_INSTR));
    check("halt_count",    cycle_count, PERF ? 32'd3 : 32'd0);
    host_valid = 1'b1; host_data = 16'h7777;
    #1;
    check("halt_no_ready", 32'(host_ready), 32'd0);
    check("halt_no_we",    32'(imem_we), 32'd0);
    step();
    step();
    host_valid = 1'b0;
    check("halt_hold",        32'(halted), 32'd1);
    check("halt_count_hold",  cycle_count, PERF ? 32'd3 : 32'd0);
    check("halt_no_writes",   32'(wr_addr_q.size()), 32'd4);

    // Reload from HALTED with a single-word program
    start = 1'b1;
    step();
    start = 1'b0;
    check("reload_halted_clr", 32'(halted), 32'd0);
    check("reload_ready",      32'(host_ready), 32'd1);
    host_valid = 1'b1; host_data = 16'hF0AA; host_last = 1'b1;
    step();
    host_valid = 1'b0; host_last = 1'b0;
    step();
    check("reload_fetch", 32'(fetch_instr), 32'h0000F0AA);
    check("reload_run",   32'(core_rst), 32'd0);
    step();
    check("reload_halted", 32'(halted), 32'd1);
    check("reload_count",  cycle_count, PERF ? 32'd1 : 32'd0);

    // Full-depth load without host_last: automatic BOOT, no wrap
    apply_reset();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      host_valid = 1'b1;
      host_data  = instruction_t'(16'h1000 + i);
      step();
    end
    host_data = 16'hBEEF;
    #1;
    check("full_boot_ready", 32'(host_ready), 32'd0);
    check("full_boot_we",    32'(imem_we), 32'd0);
    check("full_boot_busy",  32'(busy), 32'd1);
    check("full_boot_addr",  32'(imem_addr), 32'd0);
    step();
    host_valid = 1'b0;
    check("full_writes", 32'(wr_addr_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      check($sformatf("full_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
    end
    check("full_run_fetch0", 32'(fetch_instr), 32'h00001000);

    // Reset asserted mid-LOAD after two words
    apply_reset();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    host_valid = 1'b1; host_data = 16'h4001;
    step();
    host_data = 16'h4002;
    step();
    host_data = 16'h5555;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_ready", 32'(host_ready), 32'd0);
    check("abort_we",    32'(imem_we), 32'd0);
    check("abort_addr",  32'(imem_addr), 32'd0);
    step();
    check("abort_writes", 32'(wr_addr_q.size()), 32'd2);
    host_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("abort_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
